// File: rtl/mod_mult_seq_if.sv
// Operand/result bundle for mod_mult_seq: start request with operands in,
// busy/done/result/err back.
interface mod_mult_seq_if #(
    parameter int N = 6
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] m;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         err;

    modport master (
        output start, a, b, m,
        input  busy, done, result, err
    );

    modport slave (
        input  start, a, b, m,
        output busy, done, result, err
    );
endinterface

// File: rtl/mod_mult_seq.sv
// Sequential (a*b) mod m, MSB-first interleaved shift-add-reduce, one multiplier bit per clock.
// Optional operand range check (err/early done) enabled by defining MOD_MULT_RANGE_CHECK_EN.
module mod_mult_seq #(
    parameter int N = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    mod_mult_seq_if.slave bus
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = N + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   m_q, m_d;
    logic [PW-1:0]  p_q, p_d;
    logic [IW-1:0]  i_q, i_d;
    logic [N-1:0]   result_q, result_d;
    logic           err_q, err_d;
    logic           run_abort;

`ifdef MOD_MULT_RANGE_CHECK_EN
    logic           rerr_q, rerr_d;
    logic           range_bad;

    assign range_bad = (bus.a >= bus.m) || (bus.b >= bus.m) || (bus.m == '0);
    assign run_abort = rerr_q;
`else
    assign run_abort = 1'b0;
`endif

    // One RUN step: double-and-reduce, then conditional add-and-reduce.
    // The multiplier is shifted left each step so its MSB is always b[i].
    logic [PW-1:0] a_ext, m_ext, p_dbl, p_red1, p_add, p_red2;

    assign a_ext  = PW'(a_q);
    assign m_ext  = PW'(m_q);
    assign p_dbl  = {p_q[PW-2:0], 1'b0};
    assign p_red1 = (p_dbl >= m_ext) ? (p_dbl - m_ext) : p_dbl;
    assign p_add  = b_q[N-1] ? (p_red1 + a_ext) : p_red1;
    assign p_red2 = (p_add >= m_ext) ? (p_add - m_ext) : p_add;

    // NOTE: combinational blocks use blocking '=' and every target gets a
    // default first, so no path leaves a variable unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        p_d      = p_q;
        i_d      = i_q;
        result_d = result_q;
        err_d    = err_q;
`ifdef MOD_MULT_RANGE_CHECK_EN
        rerr_d   = rerr_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    m_d     = bus.m;
                    p_d     = '0;
                    i_d     = IW'(N - 1);
                    state_d = S_RUN;
`ifdef MOD_MULT_RANGE_CHECK_EN
                    rerr_d  = range_bad;
`endif
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                if (run_abort) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    p_d = p_red2;
                    b_d = b_q << 1;
                    if (i_q == '0) begin
                        result_d = p_red2[N-1:0];
                        err_d    = 1'b0;
                        state_d  = S_DONE;
                    end else begin
                        i_d = i_q - IW'(1);
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' only; the operand
    // registers are reset as well so the block comes up fully defined.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            p_q      <= '0;
            i_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
`ifdef MOD_MULT_RANGE_CHECK_EN
            rerr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            p_q      <= p_d;
            i_q      <= i_d;
            result_q <= result_d;
            err_q    <= err_d;
`ifdef MOD_MULT_RANGE_CHECK_EN
            rerr_q   <= rerr_d;
`endif
        end
    end

    assign bus.busy   = (state_q == S_RUN);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_mod_mult_seq.sv
// Scoreboard bench for mod_mult_seq: accepted requests push expected responses
// computed from (a*b)%m; a monitor pops and compares on every done pulse.
module tb_mod_mult_seq;

    localparam int N = 6;

    typedef struct {
        logic [N-1:0] res;
        bit           chk;
        bit           err;
        int           lat;
        int           acc;
    } exp_t;

    logic clk;
    logic reset_n;

    mod_mult_seq_if #(.N(N)) bus ();

    mod_mult_seq #(.N(N)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t         sb[$];
    int           done_cycs[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_acc    = 0;
    int           cyc      = 0;
    int           busy_cnt = 0;
    logic [N-1:0] last_res = '0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain modular arithmetic plus the operand-range rules.
    function automatic exp_t model(input int a, input int b, input int m, input int acc);
        exp_t e;
        bit   bad;
        bad   = (a >= m) || (b >= m) || (m == 0);
        e.acc = acc;
        e.lat = N;
        e.err = 1'b0;
        e.chk = 1'b1;
        e.res = '0;
        if (bad) begin
`ifdef MOD_MULT_RANGE_CHECK_EN
            e.err = 1'b1;
            e.lat = 1;
`else
            e.chk = (m == 1) && (a <= 1) && (b <= 1);
`endif
        end else begin
            e.res = N'((a * b) % m);
        end
        return e;
    endfunction

    // Acceptance: start seen on an edge while no operation is running.
    always @(posedge clk) begin
        cyc++;
        if (reset_n && bus.start && !bus.busy) begin
            sb.push_back(model(int'(bus.a), int'(bus.b), int'(bus.m), cyc));
            n_acc++;
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            busy_cnt = 0;
            last_res = '0;
        end else begin
            check("done_busy_excl", longint'(bus.done && bus.busy), 0);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cycs.push_back(cyc);
                check("done_has_pending", longint'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.chk) check("result", bus.result, e.res);
                    check("err", bus.err, e.err);
                    check("latency", cyc - e.acc, e.lat);
                    check("busy_cycles", busy_cnt, e.lat);
                end
                busy_cnt = 0;
                last_res = bus.result;
            end else begin
                check("result_hold", bus.result, last_res);
            end
        end
    end

    task automatic op(input int a, input int b, input int m);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = N'(a);
        bus.b     = N'(b);
        bus.m     = N'(m);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = N'($urandom);
        bus.b     = N'($urandom);
        bus.m     = N'($urandom);
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", sb.size(), 0);
        sb.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},   bus.busy,   0);
        check({tag, "_done"},   bus.done,   0);
        check({tag, "_err"},    bus.err,    0);
        check({tag, "_result"}, bus.result, 0);
    endtask

    initial begin
        int acc0;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.m     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset_n = 1'b1;

        // Directed cases.
        op(5, 7, 11);   drain();
        op(62, 62, 63); drain();
        op(0, 45, 50);  drain();
        op(1, 1, 1);    drain();

        // Start held high: back-to-back accepts, one per N+1 cycles.
        done_cycs.delete();
        acc0 = n_acc;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a = N'(3);
        bus.b = N'(4);
        bus.m = N'(13);
        repeat (20) @(posedge clk);
        #1;
        bus.start = 1'b0;
        drain();
        check("b2b_accepts", n_acc - acc0, 3);
        check("b2b_dones", done_cycs.size(), 3);
        for (int i = 1; i < done_cycs.size(); i++)
            check("b2b_spacing", done_cycs[i] - done_cycs[i-1], N + 1);

        // A start pulse during RUN must be ignored.
        done_cycs.delete();
        op(5, 7, 11);
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a = N'(1);
        bus.b = N'(1);
        bus.m = N'(3);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        drain();
        repeat (10) @(negedge clk);
        check("run_start_ignored", done_cycs.size(), 1);

        // Asynchronous reset in the middle of RUN discards the operation.
        op(20, 30, 41);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        check_idle_outputs("midrun_reset");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        op(9, 10, 17); drain();

        // Out-of-range operands.
        op(12, 3, 11); drain();
        op(5, 5, 0);   drain();

        // Random sweep over every modulus.
        for (int mm = 1; mm < 64; mm++) begin
            int ra, rb;
            ra = int'($urandom % mm);
            rb = int'($urandom % mm);
            op(ra, rb, mm);
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit at t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mod_mult_seq.md
# mod_mult_seq

Sequential modular multiplier for the RSA exponentiation datapath: computes result = (a × b) mod m with MSB-first interleaved shift-add-reduce, one multiplier bit per clock. It is the arithmetic stage driven each square/multiply step of the exponentiation loop. The loop's bit counter and operand mux select the operands and issue `start`; this block answers with `done` and `result`.

## Interface
- `N`, default 6: operand and modulus width in bits; must match the exponent-counter width used by the loop.

Ports:
- `clk`  in  1  rising-edge clock, single clock domain
- `reset_n`  in  1  asynchronous active-low reset
- `start`  in  1  request; sampled on a rising edge only in IDLE or DONE
- `a`  in  N  multiplicand; captured at accepted start
- `b`  in  N  multiplier; captured at accepted start
- `m`  in  N  modulus; captured at accepted start
- `busy`  out  1  high while an operation is in progress (RUN)
- `done`  out  1  one-cycle pulse; `result` is valid
- `result`  out  N  product mod m; held until the next accepted start
- `err`  out  1  operand-range error, valid with `done` (see Configuration)

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE with `start`=1:
  - Latch a, b, m.
  - Clear accumulator P, which is N+2 bits wide.
  - Set bit index i = N-1.
  - Go to RUN.
- IDLE/DONE with `start`=0: DONE goes to IDLE; IDLE stays in IDLE.
- RUN, once per cycle, in this order:
  - P ← 2P; if P ≥ m, P ← P−m.
  - If b[i], P ← P+a; if P ≥ m, P ← P−m.
  - Both compare-subtracts happen in the same cycle.
  - If i = 0: register P[N-1:0] into `result` and go to DONE. Otherwise i ← i−1.
- Width rules:
  - With a < m and b < m, every intermediate value is < 2m ≤ 2^(N+1), so N+2 bits never overflow.
  - Compares are unsigned, at full accumulator width.
- `start` in RUN is ignored. The operation is neither restarted nor queued.
- Operand inputs may change freely after the accepting edge.
- Precondition: a < m, b < m, m ≠ 0. Behaviour when the precondition is violated is defined only by Configuration.
- Reset at any time, including mid-RUN, gives:
  - state IDLE;
  - `busy`=0, `done`=0, `err`=0, `result`=0;
  - P=0, i=0.
  - The in-flight operation is discarded. No `done` is produced for it.

## Timing
- Accepting edge E0: `busy` rises after E0.
- Edges E1..EN: one bit processed per edge.
- At EN:
  - `result` and `err` update;
  - `busy` falls;
  - `done` is high for exactly the cycle between EN and EN+1.
- Latency: start-accept edge to `done` = N cycles.
- Back-to-back: `start` held high during the DONE cycle is accepted at EN+1. Sustained throughput is one operation per N+1 cycles.
- `done` and `busy` are never high together.
- `result` is stable from EN until the EN of the next operation.

## Configuration
- Macro: `MOD_MULT_RANGE_CHECK_EN`.
- When defined:
  - On accept, the block compares a ≥ m, b ≥ m and m = 0. This comparison is registered alongside the operands.
  - If any condition holds, the block goes from RUN to DONE on the first RUN edge, E1.
  - It then outputs `result`=0 and `err`=1, with `done` pulsing after E1. Latency is 1 cycle.
- When not defined:
  - No check is performed; `err` is constant 0.
  - Out-of-range operands still take N cycles. `result` is then unspecified but deterministic, and the FSM must not hang.

## Test plan
- N=6, a=5, b=7, m=11, `start` pulse → `busy` for 6 cycles, `done` one cycle after E6, `result`=2, `err`=0.
- N=6, a=62, b=62, m=63 → `result`=1; separately a=0, b=45, m=50 → `result`=0; a=1, b=1, m=1 is out of range (a ≥ m) → `result`=0 in both builds, with `err` per build.
- `start` held high continuously with a=3, b=4, m=13 → back-to-back results of 12, `done` every 7 cycles; `start` pulses in RUN produce no extra `done`.
- Reset asserted at cycle 3 of RUN → all outputs 0 immediately (asynchronous), no `done`; next operation a=9, b=10, m=17 → `result`=5.
- Macro defined: a=12, b=3, m=11 → `done` one cycle after accept, `err`=1, `result`=0; m=0 → `err`=1. Macro undefined: the same stimulus → `done` after 6 cycles, `err`=0.
- Random sweep N=6, all m in 1..63 with random a, b < m → `result` matches the reference model (a×b)%m, latency always 6.
